load_store_sequencer: RTL
=========================

# load_store_sequencer

Pipeline-side initiator for the byte-addressed data memory. Sits between the MEM stage and the data memory port. Aligned loads and stores pass straight through in one cycle. Misaligned halfword and word accesses are split into sequential byte accesses, stalling the pipeline until the access completes.

## Interface
- AW, 32, address width; addresses wrap modulo 2^AW.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents an access this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 load/store funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  pipeline must hold the MEM stage; req_* are ignored while high.
- rsp_valid  out  1  access completes this cycle.
- rsp_rdata  out  32  extended load data, valid with rsp_valid for loads; 0 for stores.
- misalign_err  out  1  misaligned access rejected; only exists when splitting is compiled out.
- mem_we  out  1  memory write enable.
- mem_funct3  out  3  access size and sign to memory.
- mem_a  out  AW  memory byte address.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data; combinational and valid in the same cycle.

## Operation
- Alignment rule:
  - Byte accesses are always aligned.
  - H requires addr[0]=0.
  - W requires addr[1:0]=00.
  - funct3[1:0]=11 is illegal: it is passed through as-is, with rsp_rdata=0 and no write.
- Pass-through, state IDLE with an aligned request:
  - mem_* = req_* combinationally.
  - rsp_valid=req_valid and rsp_rdata=mem_rd in the same cycle; stall=0.
- Split, with N=2 for H and N=4 for W:
  - IDLE with a misaligned request:
    - Issue byte 0 combinationally from req_*.
    - Capture we, funct3, addr and wdata.
    - Set idx=1, stall=1, and go to BYTE.
  - Each BYTE cycle:
    - mem_a = addr+idx, wrapping.
    - mem_funct3 = 100 for loads, 000 for stores.
    - mem_wd[7:0] = wdata byte idx.
    - mem_we = captured we.
  - Loads assemble bytes little-endian: byte k is taken from mem_rd[7:0] of byte access k.
  - Last byte (idx=N-1):
    - rsp_valid=1 and stall=0.
    - rsp_rdata is the assembled value: sign-extended when funct3[2]=0, zero-extended when funct3[2]=1.
    - W is never extended.
    - Return to IDLE; a new request may be accepted in the next cycle.
  - Other BYTE cycles: stall=1, rsp_valid=0, idx increments.
- Stores write bytes in ascending address order; no byte is written twice.
- While RST_N=0:
  - mem_we=0, stall=0, rsp_valid=0, rsp_rdata=0.
  - State=IDLE, idx=0, capture registers cleared.
- Reset mid-split:
  - Abort immediately with no response.
  - Bytes already stored remain in memory.

## Timing
- Aligned access: 0-cycle latency and no stall.
- Misaligned H: 2 cycles.
  - Cycle 0: byte 0, stall=1.
  - Cycle 1: byte 1, rsp_valid=1.
- Misaligned W: 4 cycles; stall is high in cycles 0-2 and rsp_valid is high in cycle 3.
- Exactly one rsp_valid pulse per accepted request.
- Back-to-back accesses:
  - A request in the cycle after rsp_valid is accepted normally.
  - req_* presented while stall=1 are not sampled.
- Address wrap: W at 0xFFFF_FFFE accesses bytes FFFF_FFFE, FFFF_FFFF, 0000_0000 and 0000_0001 (with AW=32).

## Configuration
- MISALIGN_SPLIT_EN defined: the split behaviour above; the misalign_err port is absent.
- Not defined:
  - No BYTE state and stall is tied to 0.
  - A misaligned request drives mem_we=0 and rsp_rdata=0.
  - It asserts rsp_valid=1 and misalign_err=1 for that cycle only.
  - Aligned behaviour is unchanged.

## Test plan
- Aligned LW at 0x100, with memory bytes 0x100..0x103 = 11 22 33 44 -> same cycle rsp_rdata=0x44332211, stall=0.
- Misaligned LH at 0x101 with bytes 80 FF -> cycle 0 stall=1; cycle 1 rsp_rdata=0xFFFFFF80. LHU at the same address -> 0x0000FF80.
- Misaligned SW 0xDEADBEEF at 0x203 -> 4 byte writes at 203..206 of EF BE AD DE; stall is high for 3 cycles; a following LW at 0x203 returns 0xDEADBEEF.
- SW at 0xFFFF_FFFE -> writes wrap to 0x0000_0000 and 0x0000_0001; no other address is touched.
- RST_N pulsed low after the 2nd byte of a misaligned SW at 0x301 -> bytes 0x301 and 0x302 are written, 0x303 and 0x304 are untouched; no rsp_valid; stall=0; IDLE after reset.
- MISALIGN_SPLIT_EN undefined, SH at 0x401 -> mem_we=0, misalign_err=1 for one cycle, rsp_valid=1, memory unchanged.

Source files
------------

// File: rtl/load_store_sequencer.sv
// Data-memory initiator: aligned accesses pass through, misaligned H/W are split into bytes.
// Define MISALIGN_SPLIT_EN to split; otherwise misaligned requests are rejected via misalign_err.
module load_store_sequencer #(
   parameter int AW = 32
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          req_valid,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          stall,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
`ifndef MISALIGN_SPLIT_EN
   output logic          misalign_err,
`endif
   output logic          mem_we,
   output logic [2:0]    mem_funct3,
   output logic [AW-1:0] mem_a,
   output logic [31:0]   mem_wd,
   input  logic [31:0]   mem_rd
);

   logic legal;
   logic is_h;
   logic is_w;
   logic misal;

   assign legal = req_funct3[1:0] != 2'b11;
   assign is_h  = req_funct3[1:0] == 2'b01;
   assign is_w  = req_funct3[1:0] == 2'b10;
   assign misal = req_valid &
                  ((is_h & req_addr[0]) |
                   (is_w & (req_addr[1:0] != 2'b00)));

`ifdef MISALIGN_SPLIT_EN

   typedef enum logic {
      IDLE,
      BYTE
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic          cap_we_q, cap_we_d;
   logic          cap_w_q, cap_w_d;
   logic          cap_u_q, cap_u_d;
   logic [AW-1:0] cap_a_q, cap_a_d;
   logic [31:0]   cap_wd_q, cap_wd_d;
   logic [23:0]   asm_q, asm_d;

   logic [1:0]    last;
   logic [7:0]    wd_byte;
   logic [15:0]   hw;
   logic [31:0]   ext;

   assign last = cap_w_q ? 2'd3 : 2'd1;
   assign hw   = {mem_rd[7:0], asm_q[7:0]};
   assign ext  = cap_w_q ? {mem_rd[7:0], asm_q} :
                 cap_u_q ? {16'h0, hw} :
                           {{16{hw[15]}}, hw};

   always_comb begin
      wd_byte = cap_wd_q[7:0];
      unique case (idx_q)
         2'd1: wd_byte = cap_wd_q[15:8];
         2'd2: wd_byte = cap_wd_q[23:16];
         2'd3: wd_byte = cap_wd_q[31:24];
         default: wd_byte = cap_wd_q[7:0];
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         idx_q    <= 2'd0;
         cap_we_q <= 1'b0;
         cap_w_q  <= 1'b0;
         cap_u_q  <= 1'b0;
         cap_a_q  <= '0;
         cap_wd_q <= 32'h0;
         asm_q    <= 24'h0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cap_we_q <= cap_we_d;
         cap_w_q  <= cap_w_d;
         cap_u_q  <= cap_u_d;
         cap_a_q  <= cap_a_d;
         cap_wd_q <= cap_wd_d;
         asm_q    <= asm_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cap_we_d   = cap_we_q;
      cap_w_d    = cap_w_q;
      cap_u_d    = cap_u_q;
      cap_a_d    = cap_a_q;
      cap_wd_d   = cap_wd_q;
      asm_d      = asm_q;
      mem_we     = 1'b0;
      mem_funct3 = req_funct3;
      mem_a      = req_addr;
      mem_wd     = req_wdata;
      stall      = 1'b0;
      rsp_valid  = 1'b0;
      rsp_rdata  = 32'h0;
      if (RST_N) begin
         unique case (state_q)
            IDLE: begin
               if (misal) begin
                  // byte 0 goes out now; the rest replay from the capture regs
                  mem_we     = req_we;
                  mem_funct3 = {~req_we, 2'b00};
                  mem_wd     = {24'h0, req_wdata[7:0]};
                  cap_we_d   = req_we;
                  cap_w_d    = req_funct3[1];
                  cap_u_d    = req_funct3[2];
                  cap_a_d    = req_addr;
                  cap_wd_d   = req_wdata;
                  asm_d      = {16'h0, mem_rd[7:0]};
                  idx_d      = 2'd1;
                  stall      = 1'b1;
                  state_d    = BYTE;
               end else begin
                  mem_we    = req_valid & req_we & legal;
                  rsp_valid = req_valid;
                  if (req_valid & ~req_we & legal)
                     rsp_rdata = mem_rd;
               end
            end
            BYTE: begin
               mem_we     = cap_we_q;
               mem_funct3 = {~cap_we_q, 2'b00};
               mem_a      = cap_a_q + AW'(idx_q);
               mem_wd     = {24'h0, wd_byte};
               if (idx_q == last) begin
                  rsp_valid = 1'b1;
                  rsp_rdata = cap_we_q ? 32'h0 : ext;
                  idx_d     = 2'd0;
                  state_d   = IDLE;
               end else begin
                  stall = 1'b1;
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd1)
                     asm_d[15:8] = mem_rd[7:0];
                  else
                     asm_d[23:16] = mem_rd[7:0];
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

`else

   logic unused_clk;
   assign unused_clk = CLK;

   always_comb begin
      mem_a        = req_addr;
      mem_funct3   = req_funct3;
      mem_wd       = req_wdata;
      stall        = 1'b0;
      mem_we       = 1'b0;
      rsp_valid    = 1'b0;
      rsp_rdata    = 32'h0;
      misalign_err = 1'b0;
      if (RST_N) begin
         rsp_valid    = req_valid;
         misalign_err = misal;
         mem_we       = req_valid & req_we & legal & ~misal;
         if (req_valid & ~req_we & legal & ~misal)
            rsp_rdata = mem_rd;
      end
   end

`endif

endmodule
